// File: rtl/spi_pkg.sv
// spi_pkg
//  Shared definitions for the SPI slave front end: default widths, the
//  command encoding carried in frame bits [9:8], and the controller state set.
package spi_pkg;

  localparam int unsigned FRAME_W_DEF = 10;  // cmd[9:8] + payload[7:0]
  localparam int unsigned DATA_W_DEF  = 8;   // MISO read byte
  localparam int unsigned CNT_W_DEF   = 4;   // bit counter, 2**CNT_W > FRAME_W

  // Frame command field; decoded by the RAM, only bit 9 matters here.
  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } spi_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CHK_CMD   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_READ_ADD  = 3'd3,
    ST_READ_DATA = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_shift_reg.sv
// spi_shift_reg
//  MSB-first shift register usable as SIPO (read o_data) or PISO (read
//  o_data[W-1]). A load arms a W-bit budget; each shift consumes one bit and
//  o_done rises once the budget is spent. Clear empties the register and
//  leaves it done.
// Ports
//  clk, rst_n   clock, asynchronous active-low reset
//  i_clr        zero data and budget (highest priority)
//  i_load       load i_load_data, budget = W
//  i_load_data  parallel load value
//  i_shift      shift left by one, i_ser_in enters at bit 0
//  i_ser_in     serial input
//  o_data       parallel contents (o_data[W-1] is the serial output)
//  o_done       budget exhausted
module spi_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_data,
  input  logic         i_shift,
  input  logic         i_ser_in,
  output logic [W-1:0] o_data,
  output logic         o_done
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  r_data;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_data <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_data <= i_load_data;
      r_cnt  <= CW'(W);
    end else if (i_shift) begin
      r_data <= {r_data[W-2:0], i_ser_in};
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign o_data = r_data;
  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl
//  SPI slave front end for the SPI RAM. Deserialises 10-bit MOSI frames,
//  strobes them to the RAM on rx_valid/rx_data, and for read-data frames
//  serialises the RAM's returned byte on MISO.
// Ports
//  clk       system clock, one SPI bit per rising edge
//  rst_n     asynchronous active-low reset
//  ss_n      slave select, active low; high aborts any frame
//  mosi      serial in, MSB first
//  miso      serial out, MSB first; 0 when not serialising
//  rx_data   captured frame, held between strobes
//  rx_valid  one-cycle strobe for a complete frame
//  tx_data   read byte from RAM
//  tx_valid  tx_data valid this cycle
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned FRAME_W = FRAME_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CNT_W   = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ss_n,
  input  logic               mosi,
  output logic               miso,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid
);

  spi_state_e         r_state;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic               r_rd_addr_ok;
  logic               r_rx_valid;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_frame_full;  // bit 0 captured, strobe due next edge
  logic               r_frame_sent;  // strobe issued, now holding / waiting
  logic               r_tx_latched;  // read byte taken, later tx_valid ignored

  logic               w_in_data;
  logic               w_rx_load;
  logic               w_rx_shift;
  logic               w_rx_done;
  logic [FRAME_W-1:0] w_rx_frame;
  logic               w_tx_clr;
  logic               w_tx_load;
  logic               w_tx_shift;
  logic               w_tx_done;
  logic [DATA_W-1:0]  w_tx_sreg;
  logic               w_unused_tx;

  always_comb begin
    w_in_data  = (r_state == ST_WRITE) || (r_state == ST_READ_ADD) ||
                 (r_state == ST_READ_DATA);
    // Receive register is emptied and armed on the IDLE->CHK_CMD edge so
    // bit 9 can shift straight in on the first CHK_CMD edge.
    w_rx_load  = (r_state == ST_IDLE) && !ss_n;
    w_rx_shift = !ss_n && ((r_state == ST_CHK_CMD) ||
                 (w_in_data && !r_frame_full && !r_frame_sent && !w_rx_done));
    w_tx_clr   = ss_n;
    w_tx_load  = !ss_n && (r_state == ST_READ_DATA) && r_frame_sent &&
                 !r_tx_latched && tx_valid;
    w_tx_shift = !ss_n && (r_state == ST_READ_DATA) && r_tx_latched && !w_tx_done;
  end

  spi_shift_reg #(.W(FRAME_W)) u_rx_sreg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (1'b0),
    .i_load      (w_rx_load),
    .i_load_data ('0),
    .i_shift     (w_rx_shift),
    .i_ser_in    (mosi),
    .o_data      (w_rx_frame),
    .o_done      (w_rx_done)
  );

  spi_shift_reg #(.W(DATA_W)) u_tx_sreg (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clr       (w_tx_clr),
    .i_load      (w_tx_load),
    .i_load_data (tx_data),
    .i_shift     (w_tx_shift),
    .i_ser_in    (1'b0),
    .o_data      (w_tx_sreg),
    .o_done      (w_tx_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_rd_addr_ok <= 1'b0;
      r_rx_valid   <= 1'b0;
      r_rx_data    <= '0;
      r_frame_full <= 1'b0;
      r_frame_sent <= 1'b0;
      r_tx_latched <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (ss_n) begin
        // Abort wins over any in-flight bit; rd_addr_ok is left untouched.
        r_state      <= ST_IDLE;
        r_frame_full <= 1'b0;
        r_frame_sent <= 1'b0;
        r_tx_latched <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state      <= ST_CHK_CMD;
            r_frame_full <= 1'b0;
            r_frame_sent <= 1'b0;
            r_tx_latched <= 1'b0;
          end
          ST_CHK_CMD: begin
            r_bit_cnt <= CNT_W'(FRAME_W - 2);
            if (!mosi) begin
              r_state <= ST_WRITE;
            end else if (r_rd_addr_ok) begin
              r_state <= ST_READ_DATA;
            end else begin
              r_state <= ST_READ_ADD;
            end
          end
          default: begin
            if (w_rx_shift) begin
              if (r_bit_cnt == '0) begin
                r_frame_full <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt - CNT_W'(1);
              end
            end else if (r_frame_full) begin
              r_frame_full <= 1'b0;
              r_frame_sent <= 1'b1;
              r_rx_valid   <= 1'b1;
              r_rx_data    <= w_rx_frame;
              if (r_state == ST_READ_ADD) begin
                r_rd_addr_ok <= 1'b1;
              end else if (r_state == ST_READ_DATA) begin
                r_rd_addr_ok <= 1'b0;
              end
            end else if (w_tx_load) begin
              r_tx_latched <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign rx_valid = r_rx_valid;
  assign rx_data  = r_rx_data;
  // MISO is the transmit register MSB gated by its remaining-bit budget, so
  // it drops to 0 on abort, after the last bit and asynchronously on reset.
  assign miso        = !w_tx_done && w_tx_sreg[DATA_W-1];
  assign w_unused_tx = ^w_tx_sreg[DATA_W-2:0];

endmodule

// File: tb/tb_spi_slave_ctrl.sv
module tb_spi_slave_ctrl;
  import spi_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;

  int n_total = 0;
  int n_bad   = 0;

  spi_slave_ctrl #(.FRAME_W(10), .DATA_W(8), .CNT_W(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_n     (ss_n),
    .mosi     (mosi),
    .miso     (miso),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts and ends on a falling edge with ss_n high and the DUT idle.
  // Leaves ss_n low, one edge after the rx_valid strobe.
  task automatic run_frame(input logic [9:0] f, input spi_state_e exp_st);
    int early;
    early = 0;
    ss_n = 1'b0;
    mosi = 1'b0;
    @(negedge clk);
    chk("st_chk_cmd", 32'(dut.r_state), 32'(ST_CHK_CMD));
    for (int i = 9; i >= 0; i--) begin
      mosi = f[i];
      @(negedge clk);
      if (i == 9) chk("st_decode", 32'(dut.r_state), 32'(exp_st));
      early += int'(rx_valid);
    end
    mosi = 1'b0;
    chk("no_early_strobe", 32'(early), 32'd0);
    @(negedge clk);
    chk("rx_valid_hi", 32'(rx_valid), 32'd1);
    chk("rx_data", 32'(rx_data), 32'(f));
    @(negedge clk);
    chk("rx_valid_lo", 32'(rx_valid), 32'd0);
    chk("rx_data_hold", 32'(rx_data), 32'(f));
  endtask

  task automatic end_frame();
    ss_n = 1'b1;
    mosi = 1'b0;
    @(negedge clk);
    chk("st_idle_after", 32'(dut.r_state), 32'(ST_IDLE));
  endtask

  // Shifts nbits of f, then raises ss_n on the edge that would take the next bit.
  task automatic partial(input logic [9:0] f, input int nbits);
    int strobes;
    strobes = 0;
    ss_n = 1'b0;
    mosi = 1'b0;
    @(negedge clk);
    for (int k = 0; k < nbits; k++) begin
      mosi = f[9-k];
      @(negedge clk);
      strobes += int'(rx_valid);
    end
    ss_n = 1'b1;
    mosi = f[9-nbits];
    @(negedge clk);
    chk("abort_idle", 32'(dut.r_state), 32'(ST_IDLE));
    for (int k = 0; k < 3; k++) begin
      strobes += int'(rx_valid);
      @(negedge clk);
    end
    mosi = 1'b0;
    chk("abort_no_strobe", 32'(strobes), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_byte;
    rst_n    = 1'b0;
    ss_n     = 1'b1;
    mosi     = 1'b0;
    tx_data  = 8'h00;
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data", 32'(rx_data), 32'd0);
    chk("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("rst_rd_ok", 32'(dut.r_rd_addr_ok), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write address 5
    run_frame(10'h005, ST_WRITE);
    chk("wr_addr_rd_ok", 32'(dut.r_rd_addr_ok), 32'd0);
    end_frame();

    // Write data AA; a tx_valid while holding must not reach MISO
    run_frame(10'h1AA, ST_WRITE);
    tx_valid = 1'b1;
    tx_data  = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("hold_miso_0", 32'(miso), 32'd0);
    @(negedge clk);
    chk("hold_miso_0b", 32'(miso), 32'd0);
    end_frame();

    // Abort after 6 bits of a write, then a clean frame
    partial(10'h0F0, 6);
    run_frame(10'h0C3, ST_WRITE);
    end_frame();

    // Read address 5
    run_frame(10'h205, ST_READ_ADD);
    chk("rd_add_ok_set", 32'(dut.r_rd_addr_ok), 32'd1);
    end_frame();

    // Read-data frame aborted on the bit-0 edge: no strobe, rd_addr_ok kept
    partial(10'h3FF, 9);
    chk("abort_rd_ok_kept", 32'(dut.r_rd_addr_ok), 32'd1);
    chk("abort_miso", 32'(miso), 32'd0);

    // Read data: byte AA serialised MSB first, one relatch attempt ignored
    run_frame(10'h300, ST_READ_DATA);
    chk("rd_data_ok_clr", 32'(dut.r_rd_addr_ok), 32'd0);
    chk("pre_latch_miso", 32'(miso), 32'd0);
    exp_byte = 8'hAA;
    tx_valid = 1'b1;
    tx_data  = exp_byte;
    @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      tx_valid = (i == 5);
      tx_data  = 8'h00;
      chk($sformatf("miso_bit%0d", i), 32'(miso), 32'(exp_byte[i]));
      @(negedge clk);
    end
    tx_valid = 1'b0;
    chk("miso_after", 32'(miso), 32'd0);
    end_frame();

    // Read without a stored address goes to READ_ADD
    run_frame(10'h3AB, ST_READ_ADD);
    chk("rd_noaddr_ok_set", 32'(dut.r_rd_addr_ok), 32'd1);
    end_frame();

    // Read data C5, async reset part-way through serialisation
    run_frame(10'h300, ST_READ_DATA);
    exp_byte = 8'hC5;
    tx_valid = 1'b1;
    tx_data  = exp_byte;
    @(negedge clk);
    tx_valid = 1'b0;
    for (int i = 7; i >= 5; i--) begin
      chk($sformatf("miso2_bit%0d", i), 32'(miso), 32'(exp_byte[i]));
      @(negedge clk);
    end
    chk("miso2_bit4", 32'(miso), 32'(exp_byte[4]));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_miso", 32'(miso), 32'd0);
    chk("arst_rx_valid", 32'(rx_valid), 32'd0);
    chk("arst_state", 32'(dut.r_state), 32'(ST_IDLE));
    chk("arst_rd_ok", 32'(dut.r_rd_addr_ok), 32'd0);
    ss_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
